// File: rtl/vga_pkg.sv
// ============================================================================
// Module   : vga_pkg
// Purpose  : VGA geometry constants and frame-buffer arbiter state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

  localparam int SIZE           = 12;
  localparam int H_PIXELS       = 600;
  localparam int V_PIXELS       = 300;
  localparam int PIX_PER_WORD   = 8;
  localparam int WORDS_PER_LINE = H_PIXELS / PIX_PER_WORD;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2
  } fb_state_t;

endpackage

`default_nettype wire

// File: rtl/vga_fb_arbiter_if.sv
// ============================================================================
// Module   : vga_fb_arbiter_if
// Purpose  : Line-request, host-write, memory and line-buffer bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_fb_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 15,
  parameter int LB_AW  = 7
);

  logic              line_req;
  logic [8:0]        line_num;
  logic              line_busy;
  logic              line_done;
  logic              overrun;
  logic              host_valid;
  logic              host_ready;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              lb_we;
  logic [LB_AW-1:0]  lb_addr;
  logic [DATA_W-1:0] lb_wdata;

  modport master (
    input  line_req, line_num, host_valid, host_addr, host_wdata, mem_rdata,
    output line_busy, line_done, overrun, host_ready,
           mem_en, mem_we, mem_addr, mem_wdata, lb_we, lb_addr, lb_wdata
  );

  modport slave (
    output line_req, line_num, host_valid, host_addr, host_wdata, mem_rdata,
    input  line_busy, line_done, overrun, host_ready,
           mem_en, mem_we, mem_addr, mem_wdata, lb_we, lb_addr, lb_wdata
  );

endinterface

`default_nettype wire

// File: rtl/vga_fb_addr_gen.sv
// ============================================================================
// Module   : vga_fb_addr_gen
// Purpose  : Line base multiply, word counter and last-word flag for fetches.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_fb_addr_gen #(
  parameter int ADDR_W         = 15,
  parameter int LB_AW          = 7,
  parameter int WORDS_PER_LINE = 75
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              i_start,
  input  wire logic              i_advance,
  input  wire logic [8:0]        i_line_num,
  output logic      [ADDR_W-1:0] o_rd_addr,
  output logic      [LB_AW-1:0]  o_rd_idx,
  output logic                   o_rd_last
);

  logic [ADDR_W-1:0] w_line_base;
  logic [ADDR_W-1:0] r_base;
  logic [LB_AW-1:0]  r_w;

  assign w_line_base = ADDR_W'(i_line_num) * ADDR_W'(WORDS_PER_LINE);

  // Word 0 is issued in the request cycle itself, so r_w holds the next index.
  assign o_rd_idx  = i_start ? '0 : r_w;
  assign o_rd_addr = i_start ? w_line_base : (r_base + ADDR_W'(r_w));
  assign o_rd_last = (o_rd_idx == LB_AW'(WORDS_PER_LINE - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_base <= '0;
      r_w    <= '0;
    end else if (i_start) begin
      r_base <= w_line_base;
      r_w    <= LB_AW'(1);
    end else if (i_advance) begin
      r_w    <= o_rd_last ? '0 : (r_w + LB_AW'(1));
    end
  end

endmodule

`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
// ============================================================================
// Module   : vga_fb_arbiter
// Purpose  : Shares the frame-buffer port between display line fetch and host.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int DATA_W         = 64,
  parameter int PIX_PER_WORD   = vga_pkg::PIX_PER_WORD,
  parameter int H_PIXELS       = vga_pkg::H_PIXELS,
  parameter int V_PIXELS       = vga_pkg::V_PIXELS,
  parameter int WORDS_PER_LINE = H_PIXELS / PIX_PER_WORD,
  parameter int ADDR_W         = 15,
  parameter int LB_AW          = 7
) (
  input  wire logic         clk,
  input  wire logic         rst,
  vga_fb_arbiter_if.master  bus
);

  fb_state_t         r_state;
  fb_state_t         w_state_nxt;
  logic              w_req_valid;
  logic              w_start;
  logic              w_advance;
  logic              w_rd_issue;
  logic              w_host_ready;
  logic              w_host_acc;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [LB_AW-1:0]  w_rd_idx;
  logic              w_rd_last;

  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_s1_vld;
  logic              r_s1_last;
  logic [LB_AW-1:0]  r_s1_tag;
  logic              r_s2_vld;
  logic              r_s2_last;
  logic [LB_AW-1:0]  r_s2_tag;
  logic              r_lb_we;
  logic [LB_AW-1:0]  r_lb_addr;
  logic [DATA_W-1:0] r_lb_wdata;
  logic              r_line_done;
  logic              r_overrun;

  assign w_req_valid = bus.line_req && (bus.line_num < 9'(V_PIXELS));
  assign w_rd_issue  = w_start || w_advance;
  assign w_host_acc  = bus.host_valid && w_host_ready;

  vga_fb_addr_gen #(
    .ADDR_W         (ADDR_W),
    .LB_AW          (LB_AW),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start),
    .i_advance  (w_advance),
    .i_line_num (bus.line_num),
    .o_rd_addr  (w_rd_addr),
    .o_rd_idx   (w_rd_idx),
    .o_rd_last  (w_rd_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_start      = 1'b0;
    w_advance    = 1'b0;
    w_host_ready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_host_ready = rst && !bus.line_req;
        if (w_req_valid) begin
          w_start     = 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_advance = 1'b1;
        if (w_rd_last) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (r_line_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Reads carry their line-buffer tag through a two-deep pipe that matches
  // the one-cycle memory latency plus the registered line-buffer write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_s1_vld    <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_tag    <= '0;
      r_s2_vld    <= 1'b0;
      r_s2_last   <= 1'b0;
      r_s2_tag    <= '0;
      r_lb_we     <= 1'b0;
      r_lb_addr   <= '0;
      r_lb_wdata  <= '0;
      r_line_done <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_mem_en <= w_rd_issue || w_host_acc;
      r_mem_we <= w_host_acc;
      if (w_rd_issue) begin
        r_mem_addr <= w_rd_addr;
      end else if (w_host_acc) begin
        r_mem_addr  <= bus.host_addr;
        r_mem_wdata <= bus.host_wdata;
      end
      r_s1_vld  <= w_rd_issue;
      r_s1_last <= w_rd_issue && w_rd_last;
      r_s1_tag  <= w_rd_idx;
      r_s2_vld  <= r_s1_vld;
      r_s2_last <= r_s1_last;
      r_s2_tag  <= r_s1_tag;
      r_lb_we   <= r_s2_vld;
      if (r_s2_vld) begin
        r_lb_addr  <= r_s2_tag;
        r_lb_wdata <= bus.mem_rdata;
      end
      r_line_done <= r_s2_vld && r_s2_last;
      if (bus.line_req && (r_state != ST_IDLE)) r_overrun <= 1'b1;
    end
  end

  assign bus.line_busy  = (r_state != ST_IDLE);
  assign bus.line_done  = r_line_done;
  assign bus.overrun    = r_overrun;
  assign bus.host_ready = w_host_ready;
  assign bus.mem_en     = r_mem_en;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.lb_we      = r_lb_we;
  assign bus.lb_addr    = r_lb_addr;
  assign bus.lb_wdata   = r_lb_wdata;

endmodule

`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
// ============================================================================
// Module   : tb_vga_fb_arbiter
// Purpose  : Directed self-checking bench for the frame-buffer arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_fb_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_ovr  = 1'b0;

  vga_fb_arbiter_if #(.DATA_W(64), .ADDR_W(15), .LB_AW(7)) bus ();

  vga_fb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // Memory returns its own address as data, one cycle after a read command.
  initial bus.mem_rdata = '0;
  always @(posedge clk) begin
    if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= 64'(bus.mem_addr);
  end

  task automatic test_reset();
    rst = 1'b0;
    bus.line_req = 1'b0; bus.line_num = '0;
    bus.host_valid = 1'b1; bus.host_addr = 15'h0100; bus.host_wdata = 64'hA5;
    repeat (3) @(posedge clk);
    #2;
    n_checks++; if (bus.mem_en !== 1'b0)     begin n_fail++; $display("FAIL rst_mem_en: got %b exp 0", bus.mem_en); end
    n_checks++; if (bus.mem_we !== 1'b0)     begin n_fail++; $display("FAIL rst_mem_we: got %b exp 0", bus.mem_we); end
    n_checks++; if (bus.mem_addr !== 15'h0)  begin n_fail++; $display("FAIL rst_mem_addr: got %h exp 0", bus.mem_addr); end
    n_checks++; if (bus.lb_we !== 1'b0)      begin n_fail++; $display("FAIL rst_lb_we: got %b exp 0", bus.lb_we); end
    n_checks++; if (bus.line_busy !== 1'b0)  begin n_fail++; $display("FAIL rst_busy: got %b exp 0", bus.line_busy); end
    n_checks++; if (bus.line_done !== 1'b0)  begin n_fail++; $display("FAIL rst_done: got %b exp 0", bus.line_done); end
    n_checks++; if (bus.overrun !== 1'b0)    begin n_fail++; $display("FAIL rst_overrun: got %b exp 0", bus.overrun); end
    n_checks++; if (bus.host_ready !== 1'b0) begin n_fail++; $display("FAIL rst_host_ready: got %b exp 0", bus.host_ready); end
    bus.host_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
  endtask

  task automatic test_host_write();
    bus.host_valid = 1'b1; bus.host_addr = 15'h0100; bus.host_wdata = 64'hA5;
    #1;
    n_checks++; if (bus.host_ready !== 1'b1) begin n_fail++; $display("FAIL host_ready_t0: got %b exp 1", bus.host_ready); end
    @(posedge clk); #1;
    bus.host_addr = 15'h0101; bus.host_wdata = 64'h5A;
    #1;
    n_checks++; if (bus.mem_en !== 1'b1)      begin n_fail++; $display("FAIL host_w1_en: got %b exp 1", bus.mem_en); end
    n_checks++; if (bus.mem_we !== 1'b1)      begin n_fail++; $display("FAIL host_w1_we: got %b exp 1", bus.mem_we); end
    n_checks++; if (bus.mem_addr !== 15'h0100) begin n_fail++; $display("FAIL host_w1_addr: got %h exp 0100", bus.mem_addr); end
    n_checks++; if (bus.mem_wdata !== 64'hA5) begin n_fail++; $display("FAIL host_w1_data: got %h exp a5", bus.mem_wdata); end
    n_checks++; if (bus.host_ready !== 1'b1)  begin n_fail++; $display("FAIL host_ready_t1: got %b exp 1", bus.host_ready); end
    @(posedge clk); #1;
    bus.host_valid = 1'b0;
    #1;
    n_checks++; if (bus.mem_we !== 1'b1)      begin n_fail++; $display("FAIL host_w2_we: got %b exp 1", bus.mem_we); end
    n_checks++; if (bus.mem_addr !== 15'h0101) begin n_fail++; $display("FAIL host_w2_addr: got %h exp 0101", bus.mem_addr); end
    n_checks++; if (bus.mem_wdata !== 64'h5A) begin n_fail++; $display("FAIL host_w2_data: got %h exp 5a", bus.mem_wdata); end
    @(posedge clk); #2;
    n_checks++; if (bus.mem_en !== 1'b0)      begin n_fail++; $display("FAIL host_idle_en: got %b exp 0", bus.mem_en); end
  endtask

  // Line fetch with cycle-by-cycle checks; line_req is in cycle 0.
  task automatic test_fetch(input int ln, input bit hold_host, input int dup_cyc);
    int          base;
    logic        exp_en, exp_we, exp_lb;
    logic [14:0] exp_addr;
    base = ln * 75;
    bus.line_req = 1'b1; bus.line_num = 9'(ln);
    bus.host_valid = hold_host; bus.host_addr = 15'h1234; bus.host_wdata = 64'hCAFE_0000_0000_1234;
    #1;
    n_checks++; if (bus.host_ready !== 1'b0) begin n_fail++; $display("FAIL fetch%0d ready_c0: got %b exp 0", ln, bus.host_ready); end
    for (int c = 1; c <= 79; c++) begin
      @(posedge clk); #1;
      bus.line_req = (c == dup_cyc);
      bus.line_num = (c == dup_cyc) ? 9'd5 : 9'(ln);
      if (c == 79) bus.host_valid = 1'b0;
      #1;
      if (dup_cyc > 0 && c > dup_cyc) exp_ovr = 1'b1;
      exp_en   = (c <= 75) || (hold_host && c == 79);
      exp_we   = hold_host && (c == 79);
      exp_lb   = (c >= 3) && (c <= 77);
      exp_addr = (c <= 75) ? 15'(base + c - 1) : 15'h1234;
      n_checks++; if (bus.mem_en !== exp_en) begin n_fail++; $display("FAIL fetch%0d c%0d mem_en: got %b exp %b", ln, c, bus.mem_en, exp_en); end
      n_checks++; if (bus.mem_we !== exp_we) begin n_fail++; $display("FAIL fetch%0d c%0d mem_we: got %b exp %b", ln, c, bus.mem_we, exp_we); end
      if (exp_en) begin
        n_checks++; if (bus.mem_addr !== exp_addr) begin n_fail++; $display("FAIL fetch%0d c%0d mem_addr: got %0d exp %0d", ln, c, bus.mem_addr, exp_addr); end
      end
      if (exp_we) begin
        n_checks++; if (bus.mem_wdata !== 64'hCAFE_0000_0000_1234) begin n_fail++; $display("FAIL fetch%0d host_data: got %h", ln, bus.mem_wdata); end
      end
      n_checks++; if (bus.lb_we !== exp_lb) begin n_fail++; $display("FAIL fetch%0d c%0d lb_we: got %b exp %b", ln, c, bus.lb_we, exp_lb); end
      if (exp_lb) begin
        n_checks++; if (bus.lb_addr !== 7'(c - 3)) begin n_fail++; $display("FAIL fetch%0d c%0d lb_addr: got %0d exp %0d", ln, c, bus.lb_addr, c - 3); end
        n_checks++; if (bus.lb_wdata !== 64'(base + c - 3)) begin n_fail++; $display("FAIL fetch%0d c%0d lb_wdata: got %0d exp %0d", ln, c, bus.lb_wdata, base + c - 3); end
      end
      n_checks++; if (bus.line_done !== (c == 77)) begin n_fail++; $display("FAIL fetch%0d c%0d line_done: got %b", ln, c, bus.line_done); end
      n_checks++; if (bus.line_busy !== (c <= 77)) begin n_fail++; $display("FAIL fetch%0d c%0d line_busy: got %b", ln, c, bus.line_busy); end
      n_checks++; if (bus.host_ready !== (c >= 78)) begin n_fail++; $display("FAIL fetch%0d c%0d host_ready: got %b", ln, c, bus.host_ready); end
      n_checks++; if (bus.overrun !== exp_ovr) begin n_fail++; $display("FAIL fetch%0d c%0d overrun: got %b exp %b", ln, c, bus.overrun, exp_ovr); end
    end
    bus.line_req = 1'b0;
    bus.host_valid = 1'b0;
  endtask

  task automatic test_invalid_line();
    bus.line_req = 1'b1; bus.line_num = 9'd300;
    #1;
    n_checks++; if (bus.host_ready !== 1'b0) begin n_fail++; $display("FAIL inv_ready_c0: got %b exp 0", bus.host_ready); end
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      bus.line_req = 1'b0;
      #1;
      n_checks++; if (bus.mem_en !== 1'b0)    begin n_fail++; $display("FAIL inv c%0d mem_en: got %b exp 0", c, bus.mem_en); end
      n_checks++; if (bus.lb_we !== 1'b0)     begin n_fail++; $display("FAIL inv c%0d lb_we: got %b exp 0", c, bus.lb_we); end
      n_checks++; if (bus.line_done !== 1'b0) begin n_fail++; $display("FAIL inv c%0d line_done: got %b exp 0", c, bus.line_done); end
      n_checks++; if (bus.line_busy !== 1'b0) begin n_fail++; $display("FAIL inv c%0d busy: got %b exp 0", c, bus.line_busy); end
      n_checks++; if (bus.overrun !== exp_ovr) begin n_fail++; $display("FAIL inv c%0d overrun: got %b exp %b", c, bus.overrun, exp_ovr); end
    end
  endtask

  task automatic test_reset_mid_fetch();
    bus.line_req = 1'b1; bus.line_num = 9'd1; bus.host_valid = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      bus.line_req = 1'b0;
    end
    #1;
    n_checks++; if (bus.lb_we !== 1'b1) begin n_fail++; $display("FAIL mid_pre lb_we: got %b exp 1", bus.lb_we); end
    rst = 1'b0;
    #1;
    n_checks++; if (bus.mem_en !== 1'b0)     begin n_fail++; $display("FAIL mid_rst mem_en: got %b exp 0", bus.mem_en); end
    n_checks++; if (bus.mem_addr !== 15'h0)  begin n_fail++; $display("FAIL mid_rst mem_addr: got %h exp 0", bus.mem_addr); end
    n_checks++; if (bus.lb_we !== 1'b0)      begin n_fail++; $display("FAIL mid_rst lb_we: got %b exp 0", bus.lb_we); end
    n_checks++; if (bus.lb_addr !== 7'h0)    begin n_fail++; $display("FAIL mid_rst lb_addr: got %h exp 0", bus.lb_addr); end
    n_checks++; if (bus.lb_wdata !== 64'h0)  begin n_fail++; $display("FAIL mid_rst lb_wdata: got %h exp 0", bus.lb_wdata); end
    n_checks++; if (bus.line_busy !== 1'b0)  begin n_fail++; $display("FAIL mid_rst busy: got %b exp 0", bus.line_busy); end
    n_checks++; if (bus.overrun !== 1'b0)    begin n_fail++; $display("FAIL mid_rst overrun: got %b exp 0", bus.overrun); end
    n_checks++; if (bus.host_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst host_ready: got %b exp 0", bus.host_ready); end
    exp_ovr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #2;
      n_checks++; if (bus.lb_we !== 1'b0)      begin n_fail++; $display("FAIL post_rst c%0d lb_we: got %b exp 0", c, bus.lb_we); end
      n_checks++; if (bus.line_done !== 1'b0)  begin n_fail++; $display("FAIL post_rst c%0d line_done: got %b exp 0", c, bus.line_done); end
      n_checks++; if (bus.mem_en !== 1'b0)     begin n_fail++; $display("FAIL post_rst c%0d mem_en: got %b exp 0", c, bus.mem_en); end
      n_checks++; if (bus.host_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst c%0d host_ready: got %b exp 1", c, bus.host_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_host_write();
    @(posedge clk); #1;
    test_fetch(2, 1'b0, -1);
    @(posedge clk); #1;
    test_fetch(299, 1'b0, -1);
    @(posedge clk); #1;
    test_invalid_line();
    @(posedge clk); #1;
    test_fetch(5, 1'b1, -1);
    @(posedge clk); #1;
    test_fetch(7, 1'b0, 40);
    @(posedge clk); #1;
    test_reset_mid_fetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
